// File: rtl/vending_pkg.sv
// Shared types and defaults for the multi-product vending controller:
// FSM state encoding, credit-accumulator operations, coin codes and price tables.
package vending_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_VEND    = 2'd1,
        ST_CHANGE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ACC_HOLD = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2,
        ACC_CLR  = 2'd3
    } acc_op_e;

    localparam logic [1:0] C10  = 2'd0;
    localparam logic [1:0] C20  = 2'd1;
    localparam logic [1:0] C50  = 2'd2;
    localparam logic [1:0] C100 = 2'd3;

    // Packed tables, entry 0 in the least significant byte.
    localparam logic [31:0] DEF_COIN_VALS   = {8'd100, 8'd50, 8'd20, 8'd10};
    localparam logic [31:0] DEF_ITEM_PRICES = {8'd150, 8'd100, 8'd70, 8'd40};

endpackage

// File: rtl/vend_credit_acc.sv
// Credit register with ceiling and affordability checks; arithmetic is one bit
// wider than the credit so neither add nor subtract can wrap.
module vend_credit_acc
    import vending_pkg::*;
#(
    parameter int CREDIT_W   = 8,
    parameter int CREDIT_MAX = 200
) (
    input  logic                clk,
    input  logic                reset,
    input  acc_op_e             op,
    input  logic [CREDIT_W-1:0] coin_val,
    input  logic [CREDIT_W-1:0] price,
    output logic                coin_fits,
    output logic                price_ok,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W:0] LIMIT = (CREDIT_W+1)'(CREDIT_MAX);

    logic [CREDIT_W:0] sum;
    logic [CREDIT_W:0] diff;

    assign sum       = {1'b0, credit} + {1'b0, coin_val};
    assign diff      = {1'b0, credit} - {1'b0, price};
    assign coin_fits = (sum <= LIMIT);
    // A clear borrow bit means credit >= price.
    assign price_ok  = ~diff[CREDIT_W];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit <= '0;
        end else begin
            case (op)
                ACC_ADD: if (coin_fits) credit <= sum[CREDIT_W-1:0];
                ACC_SUB: if (price_ok)  credit <= diff[CREDIT_W-1:0];
                ACC_CLR: credit <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vending_ctrl_multi.sv
// Multi-product vending controller: COLLECT/VEND/CHANGE FSM with per-cycle
// cancel > select > coin arbitration; every output comes straight from a flop.
module vending_ctrl_multi
    import vending_pkg::*;
#(
    parameter int                             NUM_ITEMS   = 4,
    parameter int                             CREDIT_W    = 8,
    parameter int                             CREDIT_MAX  = 200,
    parameter logic [4*CREDIT_W-1:0]          COIN_VALS   = DEF_COIN_VALS,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0]  ITEM_PRICES = DEF_ITEM_PRICES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         coin_valid,
    input  logic [1:0]                   coin,
    input  logic                         sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] sel,
    input  logic                         cancel,
    input  logic                         change_ack,
    output logic                         vend,
    output logic [$clog2(NUM_ITEMS)-1:0] vend_item,
    output logic                         change_valid,
    output logic [CREDIT_W-1:0]          change_amt,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         coin_reject,
    output logic                         sel_denied,
    output logic                         busy
);

    localparam int SEL_W    = $clog2(NUM_ITEMS);
    localparam int SEL_SPAN = 1 << SEL_W;
    // One bit per encodable index; set only for indices naming a real product.
    localparam logic [SEL_SPAN-1:0] ITEM_MASK = {SEL_SPAN{1'b1}} >> (SEL_SPAN - NUM_ITEMS);

    localparam logic [1:0] COLLECT = ST_COLLECT;
    localparam logic [1:0] VEND    = ST_VEND;
    localparam logic [1:0] CHANGE  = ST_CHANGE;

    logic [1:0]          state;
    logic [1:0]          next_state;
    acc_op_e             acc_op;
    logic                coin_take;
    logic                deny;
    logic                load_change;
    logic                sel_in_range;
    logic [SEL_W-1:0]    sel_idx;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W-1:0] coin_val;
    logic                coin_fits;
    logic                price_ok;

    assign sel_in_range = ITEM_MASK[sel];
    assign sel_idx      = sel_in_range ? sel : '0;
    assign price        = ITEM_PRICES[int'(sel_idx)*CREDIT_W +: CREDIT_W];
    assign coin_val     = COIN_VALS[int'(coin)*CREDIT_W +: CREDIT_W];

    vend_credit_acc #(
        .CREDIT_W   (CREDIT_W),
        .CREDIT_MAX (CREDIT_MAX)
    ) u_credit (
        .clk       (clk),
        .reset     (reset),
        .op        (acc_op),
        .coin_val  (coin_val),
        .price     (price),
        .coin_fits (coin_fits),
        .price_ok  (price_ok),
        .credit    (credit)
    );

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state  = state;
        acc_op      = ACC_HOLD;
        coin_take   = 1'b0;
        deny        = 1'b0;
        load_change = 1'b0;
        case (state)
            COLLECT: begin
                if (cancel) begin
                    if (credit != '0) begin
                        acc_op      = ACC_CLR;
                        load_change = 1'b1;
                        next_state  = CHANGE;
                    end
                end else if (sel_valid) begin
                    if (sel_in_range && price_ok) begin
                        acc_op     = ACC_SUB;
                        next_state = VEND;
                    end else begin
                        deny = 1'b1;
                    end
                end else if (coin_valid && coin_fits) begin
                    acc_op    = ACC_ADD;
                    coin_take = 1'b1;
                end
            end
            VEND: begin
                if (credit != '0) begin
                    acc_op      = ACC_CLR;
                    load_change = 1'b1;
                    next_state  = CHANGE;
                end else begin
                    next_state = COLLECT;
                end
            end
            CHANGE: if (change_ack) next_state = COLLECT;
            default: next_state = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= COLLECT;
            vend         <= 1'b0;
            vend_item    <= '0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            coin_reject  <= 1'b0;
            sel_denied   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= next_state;
            vend         <= (next_state == VEND);
            change_valid <= (next_state == CHANGE);
            busy         <= (next_state != COLLECT);
            coin_reject  <= coin_valid && !coin_take;
            sel_denied   <= deny;
            if (next_state == VEND) vend_item <= sel;
            // credit still holds the amount being refunded when the change is loaded.
            if (load_change) change_amt <= credit;
            else if (state == CHANGE && change_ack) change_amt <= '0;
        end
    end

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// Scenario bench for vending_ctrl_multi: expected vend items and change amounts
// are queued as stimulus is driven and popped when the DUT presents them.
module tb_vending_ctrl_multi;
    import vending_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       change_ack;
    logic       vend;
    logic [1:0] vend_item;
    logic       change_valid;
    logic [7:0] change_amt;
    logic [7:0] credit;
    logic       coin_reject;
    logic       sel_denied;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [1:0] exp_items[$];
    logic [7:0] exp_change[$];
    logic [1:0] e_item;
    logic [7:0] e_amt;

    vending_ctrl_multi dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin         (coin),
        .sel_valid    (sel_valid),
        .sel          (sel),
        .cancel       (cancel),
        .change_ack   (change_ack),
        .vend         (vend),
        .vend_item    (vend_item),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .sel_denied   (sel_denied),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one rising edge and settle, so registered outputs can be sampled.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        coin_valid = 1'b0;
        coin       = C10;
        sel_valid  = 1'b0;
        sel        = 2'd0;
        cancel     = 1'b0;
        change_ack = 1'b0;
    endtask

    task automatic put_coin(input logic [1:0] code);
        idle();
        coin_valid = 1'b1;
        coin       = code;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        cycle();
        cycle();
        vectors++; if (credit !== 8'd0) begin miscompares++; $display("FAIL reset_credit: got %0d want 0", credit); end
        vectors++; if ({vend, change_valid, coin_reject, sel_denied, busy} !== 5'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 00000", {vend, change_valid, coin_reject, sel_denied, busy}); end
        vectors++; if (change_amt !== 8'd0 || vend_item !== 2'd0) begin miscompares++; $display("FAIL reset_values: change_amt %0d vend_item %0d want 0 0", change_amt, vend_item); end
        #2 reset = 1'b0;
        cycle();
    endtask

    task automatic test_exact_pay();
        put_coin(C20);
        vectors++; if (credit !== 8'd20) begin miscompares++; $display("FAIL exact_credit20: got %0d want 20", credit); end
        put_coin(C20);
        vectors++; if (credit !== 8'd40) begin miscompares++; $display("FAIL exact_credit40: got %0d want 40", credit); end
        sel_valid = 1'b1; sel = 2'd0; exp_items.push_back(2'd0);
        cycle(); idle();
        vectors++; if (vend !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL exact_vend: vend %b busy %b want 1 1", vend, busy); end
        if (vend === 1'b1) begin
            e_item = exp_items.pop_front();
            vectors++; if (vend_item !== e_item) begin miscompares++; $display("FAIL exact_item: got %0d want %0d", vend_item, e_item); end
        end
        vectors++; if (credit !== 8'd0) begin miscompares++; $display("FAIL exact_credit0: got %0d want 0", credit); end
        cycle();
        vectors++; if ({vend, change_valid, busy} !== 3'b000) begin miscompares++; $display("FAIL exact_done: vend/change_valid/busy %b want 000", {vend, change_valid, busy}); end
    endtask

    task automatic test_change_hold();
        put_coin(C50);
        put_coin(C50);
        vectors++; if (credit !== 8'd100) begin miscompares++; $display("FAIL hold_credit100: got %0d want 100", credit); end
        sel_valid = 1'b1; sel = 2'd1;
        exp_items.push_back(2'd1); exp_change.push_back(8'd30);
        cycle(); idle();
        vectors++; if (vend !== 1'b1 || credit !== 8'd30) begin miscompares++; $display("FAIL hold_vend: vend %b credit %0d want 1 30", vend, credit); end
        if (vend === 1'b1) begin
            e_item = exp_items.pop_front();
            vectors++; if (vend_item !== e_item) begin miscompares++; $display("FAIL hold_item: got %0d want %0d", vend_item, e_item); end
        end
        cycle();
        vectors++; if (change_valid !== 1'b1 || vend !== 1'b0) begin miscompares++; $display("FAIL hold_change_valid: change_valid %b vend %b want 1 0", change_valid, vend); end
        e_amt = 8'd0;
        if (change_valid === 1'b1) begin
            e_amt = exp_change.pop_front();
            vectors++; if (change_amt !== e_amt) begin miscompares++; $display("FAIL hold_amt: got %0d want %0d", change_amt, e_amt); end
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++; if (change_valid !== 1'b1 || change_amt !== e_amt) begin miscompares++; $display("FAIL hold_stable%0d: change_valid %b amt %0d want 1 %0d", i, change_valid, change_amt, e_amt); end
        end
        change_ack = 1'b1;
        cycle(); idle();
        vectors++; if ({change_valid, busy} !== 2'b00 || change_amt !== 8'd0 || credit !== 8'd0) begin miscompares++; $display("FAIL hold_ack: cv/busy %b amt %0d credit %0d want 00 0 0", {change_valid, busy}, change_amt, credit); end
    endtask

    task automatic test_limit();
        put_coin(C100);
        put_coin(C100);
        vectors++; if (credit !== 8'd200) begin miscompares++; $display("FAIL limit_credit200: got %0d want 200", credit); end
        put_coin(C10);
        vectors++; if (coin_reject !== 1'b1 || credit !== 8'd200) begin miscompares++; $display("FAIL limit_reject: coin_reject %b credit %0d want 1 200", coin_reject, credit); end
        cycle();
        vectors++; if (coin_reject !== 1'b0) begin miscompares++; $display("FAIL limit_reject_pulse: got %b want 0", coin_reject); end
        sel_valid = 1'b1; sel = 2'd3;
        exp_items.push_back(2'd3); exp_change.push_back(8'd50);
        cycle(); idle();
        vectors++; if (vend !== 1'b1) begin miscompares++; $display("FAIL limit_vend: got %b want 1", vend); end
        if (vend === 1'b1) begin
            e_item = exp_items.pop_front();
            vectors++; if (vend_item !== e_item) begin miscompares++; $display("FAIL limit_item: got %0d want %0d", vend_item, e_item); end
        end
        coin_valid = 1'b1; coin = C10;
        cycle(); idle();
        vectors++; if (coin_reject !== 1'b1) begin miscompares++; $display("FAIL limit_vend_coin: coin_reject %b want 1", coin_reject); end
        if (change_valid === 1'b1) begin
            e_amt = exp_change.pop_front();
            vectors++; if (change_amt !== e_amt) begin miscompares++; $display("FAIL limit_amt: got %0d want %0d", change_amt, e_amt); end
        end else begin
            vectors++; miscompares++; $display("FAIL limit_change_valid: got %b want 1", change_valid);
        end
        change_ack = 1'b1;
        cycle(); idle();
        vectors++; if (change_valid !== 1'b0 || credit !== 8'd0) begin miscompares++; $display("FAIL limit_ack: change_valid %b credit %0d want 0 0", change_valid, credit); end
    endtask

    task automatic test_denied_cancel();
        put_coin(C20);
        sel_valid = 1'b1; sel = 2'd2;
        cycle(); idle();
        vectors++; if (sel_denied !== 1'b1 || credit !== 8'd20 || vend !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL deny_pulse: sel_denied %b credit %0d vend %b busy %b want 1 20 0 0", sel_denied, credit, vend, busy); end
        cycle();
        vectors++; if (sel_denied !== 1'b0) begin miscompares++; $display("FAIL deny_pulse_end: got %b want 0", sel_denied); end
        cancel = 1'b1; exp_change.push_back(8'd20);
        cycle(); idle();
        vectors++; if (change_valid !== 1'b1 || credit !== 8'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL cancel_state: change_valid %b credit %0d busy %b want 1 0 1", change_valid, credit, busy); end
        e_amt = exp_change.pop_front();
        vectors++; if (change_amt !== e_amt) begin miscompares++; $display("FAIL cancel_amt: got %0d want %0d", change_amt, e_amt); end
        coin_valid = 1'b1; coin = C10; sel_valid = 1'b1; sel = 2'd0;
        cycle(); idle();
        vectors++; if (coin_reject !== 1'b1 || sel_denied !== 1'b0 || vend !== 1'b0 || change_amt !== e_amt) begin miscompares++; $display("FAIL change_busy_inputs: rej %b deny %b vend %b amt %0d want 1 0 0 %0d", coin_reject, sel_denied, vend, change_amt, e_amt); end
        change_ack = 1'b1;
        cycle(); idle();
        vectors++; if (change_valid !== 1'b0 || change_amt !== 8'd0) begin miscompares++; $display("FAIL cancel_ack: change_valid %b amt %0d want 0 0", change_valid, change_amt); end
    endtask

    task automatic test_arbitration();
        put_coin(C50);
        cancel = 1'b1; sel_valid = 1'b1; sel = 2'd0; coin_valid = 1'b1; coin = C10;
        exp_change.push_back(8'd50);
        cycle(); idle();
        vectors++; if (vend !== 1'b0 || coin_reject !== 1'b1 || sel_denied !== 1'b0 || credit !== 8'd0) begin miscompares++; $display("FAIL arb_flags: vend %b rej %b deny %b credit %0d want 0 1 0 0", vend, coin_reject, sel_denied, credit); end
        if (change_valid === 1'b1) begin
            e_amt = exp_change.pop_front();
            vectors++; if (change_amt !== e_amt) begin miscompares++; $display("FAIL arb_amt: got %0d want %0d", change_amt, e_amt); end
        end else begin
            vectors++; miscompares++; $display("FAIL arb_change_valid: got %b want 1", change_valid);
        end
        change_ack = 1'b1;
        cycle(); idle();
    endtask

    task automatic test_back_to_back();
        put_coin(C20);
        put_coin(C20);
        sel_valid = 1'b1; sel = 2'd0; coin_valid = 1'b1; coin = C50;
        exp_items.push_back(2'd0);
        cycle(); idle();
        vectors++; if (vend !== 1'b1 || coin_reject !== 1'b1 || credit !== 8'd0) begin miscompares++; $display("FAIL b2b_vend: vend %b rej %b credit %0d want 1 1 0", vend, coin_reject, credit); end
        if (vend === 1'b1) begin
            e_item = exp_items.pop_front();
            vectors++; if (vend_item !== e_item) begin miscompares++; $display("FAIL b2b_item: got %0d want %0d", vend_item, e_item); end
        end
        coin_valid = 1'b1; coin = C10;
        cycle(); idle();
        vectors++; if (coin_reject !== 1'b1 || vend !== 1'b0 || credit !== 8'd0) begin miscompares++; $display("FAIL b2b_vend_coin: rej %b vend %b credit %0d want 1 0 0", coin_reject, vend, credit); end
        put_coin(C10);
        vectors++; if (credit !== 8'd10 || coin_reject !== 1'b0) begin miscompares++; $display("FAIL b2b_next_coin: credit %0d rej %b want 10 0", credit, coin_reject); end
        cancel = 1'b1; cycle(); idle();
        change_ack = 1'b1; cycle(); idle();
        vectors++; if (change_valid !== 1'b0 || credit !== 8'd0) begin miscompares++; $display("FAIL b2b_clean: change_valid %b credit %0d want 0 0", change_valid, credit); end
    endtask

    task automatic test_reset_abort();
        put_coin(C50);
        put_coin(C50);
        sel_valid = 1'b1; sel = 2'd1;
        exp_items.push_back(2'd1); exp_change.push_back(8'd30);
        cycle(); idle();
        if (vend === 1'b1) e_item = exp_items.pop_front();
        cycle();
        e_amt = exp_change.pop_front();
        vectors++; if (change_valid !== 1'b1 || change_amt !== e_amt) begin miscompares++; $display("FAIL abort_setup: change_valid %b amt %0d want 1 %0d", change_valid, change_amt, e_amt); end
        #2 reset = 1'b1;
        #1;
        vectors++; if ({vend, change_valid, coin_reject, sel_denied, busy} !== 5'b0 || change_amt !== 8'd0 || credit !== 8'd0) begin miscompares++; $display("FAIL abort_async: flags %b amt %0d credit %0d want 00000 0 0", {vend, change_valid, coin_reject, sel_denied, busy}, change_amt, credit); end
        cycle();
        #2 reset = 1'b0;
        cycle();
        vectors++; if (change_valid !== 1'b0 || busy !== 1'b0 || vend !== 1'b0) begin miscompares++; $display("FAIL abort_release: cv %b busy %b vend %b want 0 0 0", change_valid, busy, vend); end
        put_coin(C10);
        vectors++; if (credit !== 8'd10) begin miscompares++; $display("FAIL abort_collect: credit %0d want 10", credit); end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_exact_pay();
        test_change_hold();
        test_limit();
        test_denied_cancel();
        test_arbitration();
        test_back_to_back();
        test_reset_abort();
        vectors++;
        if (exp_items.size() != 0 || exp_change.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d items and %0d change amounts never observed", exp_items.size(), exp_change.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
